// File: rtl/axi_wdg_pkg.sv
// Shared types and defaults for the outbound AXI watchdog.
// wdg_state_e     : isolation FSM state encoding.
// DefaultCntWidth : default width of the stall timers and the timeout threshold.
package axi_wdg_pkg;

    localparam int DefaultCntWidth = 16;

    typedef enum logic [1:0] {
        MONITOR   = 2'd0,
        ISOLATING = 2'd1,
        ISOLATED  = 2'd2,
        RELEASE   = 2'd3
    } wdg_state_e;

endpackage

// File: rtl/secure_subsystem_synth_pkg.sv
// Synthesis-wide constants shared by the secure subsystem blocks.
// AxiMaxOutTrans : maximum outstanding AXI transactions per direction on the
//                  outbound master port.
package secure_subsystem_synth_pkg;

    localparam int AxiMaxOutTrans = 8;

endpackage

// File: rtl/axi_wdg_chan_tracker.sv
// Per-direction tracker: counts outstanding transactions and times stalls.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   inc_i, dec_i   : request accepted / response completed this cycle
//   progress_i     : any data or response beat moved this cycle
//   enable_i       : stall timer may run (watchdog enabled and monitoring)
//   flush_i        : zero the counter and the timer this cycle
//   threshold_i    : stall threshold in cycles, 0 disables the timeout strobe
//   count_o        : outstanding transaction count
//   overflow_o     : strobe, increment attempted at full count
//   underflow_o    : strobe, decrement attempted at zero
//   timeout_o      : strobe, stall timer has reached the threshold
module axi_wdg_chan_tracker #(
    parameter int MaxCount = 8,
    parameter int CntWidth = 16,
    parameter int OutWidth = $clog2(MaxCount + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic                progress_i,
    input  logic                enable_i,
    input  logic                flush_i,
    input  logic [CntWidth-1:0] threshold_i,
    output logic [OutWidth-1:0] count_o,
    output logic                overflow_o,
    output logic                underflow_o,
    output logic                timeout_o
);

    localparam logic [OutWidth-1:0] CountMax = OutWidth'(MaxCount);
    localparam logic [CntWidth-1:0] TimerMax = '1;

    logic [OutWidth-1:0] count_q, count_d;
    logic [CntWidth-1:0] timer_q, timer_d;

    // Outstanding counter. A simultaneous increment and decrement cancel out,
    // so the saturation checks only apply to a lone increment or decrement.
    always_comb begin
        count_d     = count_q;
        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        if (flush_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i) begin
            if (count_q == CountMax) begin
                overflow_o = 1'b1;
            end else begin
                count_d = count_q + OutWidth'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                count_d = count_q - OutWidth'(1);
            end
        end
    end

    // Stall timer: runs only while something is outstanding and nothing moves;
    // any beat or an empty counter drops it back to zero. Saturates at all-ones.
    always_comb begin
        timer_d = '0;
        if (!flush_i && enable_i && (count_q != '0) && !progress_i) begin
            timer_d = (timer_q == TimerMax) ? timer_q : timer_q + CntWidth'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            timer_q <= '0;
        end else begin
            count_q <= count_d;
            timer_q <= timer_d;
        end
    end

    assign timeout_o = enable_i && (threshold_i != '0) && (timer_q == threshold_i);
    assign count_o   = count_q;

endmodule

// File: rtl/axi_out_watchdog.sv
// Outbound AXI watchdog: passive monitor that counts outstanding reads and
// writes, detects stalled traffic and requests isolation of the master port
// until software clears the error.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   enable_i              : monitoring enable
//   timeout_i             : stall threshold in cycles, 0 disables timeout
//   clear_i               : clears sticky errors, releases isolation
//   aw/w/b/ar/r handshake : observed AXI valid/ready (and r_last_i)
//   isolated_i            : isolation status from the isolation stage
//   isolate_req_o         : isolation request
//   timeout_o, proto_err_o: sticky error flags
//   irq_o                 : one-cycle pulse when a sticky flag first sets
//   wr/rd_outstanding_o   : outstanding transaction counts
module axi_out_watchdog
    import axi_wdg_pkg::*;
#(
    parameter int MaxOutstanding = secure_subsystem_synth_pkg::AxiMaxOutTrans,
    parameter int CntWidth       = DefaultCntWidth,
    parameter int OutWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [CntWidth-1:0] timeout_i,
    input  logic                clear_i,
    input  logic                aw_valid_i,
    input  logic                aw_ready_i,
    input  logic                w_valid_i,
    input  logic                w_ready_i,
    input  logic                b_valid_i,
    input  logic                b_ready_i,
    input  logic                ar_valid_i,
    input  logic                ar_ready_i,
    input  logic                r_valid_i,
    input  logic                r_ready_i,
    input  logic                r_last_i,
    input  logic                isolated_i,
    output logic                isolate_req_o,
    output logic                timeout_o,
    output logic                proto_err_o,
    output logic                irq_o,
    output logic [OutWidth-1:0] wr_outstanding_o,
    output logic [OutWidth-1:0] rd_outstanding_o
);

    wdg_state_e state_q, state_d;

    logic awHs, wHs, bHs, arHs, rHs;
    logic trackEnable, flushCounters, clearAllowed;
    logic wrOverflow, wrUnderflow, wrTimeout;
    logic rdOverflow, rdUnderflow, rdTimeout;
    logic stallTimeout, protoEvent;
    logic timeoutFlag_q, timeoutFlag_d;
    logic protoFlag_q, protoFlag_d;
    logic timeoutDly_q, protoDly_q, irq_q;

    assign awHs = aw_valid_i & aw_ready_i;
    assign wHs  = w_valid_i & w_ready_i;
    assign bHs  = b_valid_i & b_ready_i;
    assign arHs = ar_valid_i & ar_ready_i;
    assign rHs  = r_valid_i & r_ready_i;

    // Timers only run while monitoring; the software clear in ISOLATED
    // restarts bookkeeping from an empty bus.
    assign trackEnable   = enable_i && (state_q == MONITOR);
    assign flushCounters = clear_i && (state_q == ISOLATED);
    assign clearAllowed  = clear_i && (state_q != ISOLATING);

    axi_wdg_chan_tracker #(
        .MaxCount (MaxOutstanding),
        .CntWidth (CntWidth),
        .OutWidth (OutWidth)
    ) u_wr_tracker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (awHs),
        .dec_i       (bHs),
        .progress_i  (wHs | bHs),
        .enable_i    (trackEnable),
        .flush_i     (flushCounters),
        .threshold_i (timeout_i),
        .count_o     (wr_outstanding_o),
        .overflow_o  (wrOverflow),
        .underflow_o (wrUnderflow),
        .timeout_o   (wrTimeout)
    );

    axi_wdg_chan_tracker #(
        .MaxCount (MaxOutstanding),
        .CntWidth (CntWidth),
        .OutWidth (OutWidth)
    ) u_rd_tracker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (arHs),
        .dec_i       (rHs & r_last_i),
        .progress_i  (rHs),
        .enable_i    (trackEnable),
        .flush_i     (flushCounters),
        .threshold_i (timeout_i),
        .count_o     (rd_outstanding_o),
        .overflow_o  (rdOverflow),
        .underflow_o (rdUnderflow),
        .timeout_o   (rdTimeout)
    );

    assign stallTimeout = (wrTimeout | rdTimeout) && (state_q == MONITOR);
    assign protoEvent   = wrOverflow | wrUnderflow | rdOverflow | rdUnderflow;

    // Isolation FSM next state. The request is held through ISOLATING and
    // ISOLATED and dropped in RELEASE while the isolation stage lets go.
    always_comb begin
        state_d       = state_q;
        isolate_req_o = 1'b0;
        case (state_q)
            MONITOR: begin
                if (stallTimeout) state_d = ISOLATING;
            end
            ISOLATING: begin
                isolate_req_o = 1'b1;
                if (isolated_i) state_d = ISOLATED;
            end
            ISOLATED: begin
                isolate_req_o = 1'b1;
                if (clear_i) state_d = RELEASE;
            end
            RELEASE: begin
                if (!isolated_i) state_d = MONITOR;
            end
            default: state_d = MONITOR;
        endcase
    end

    // Sticky flags. A new error in the same cycle as a clear wins, so an
    // error is never silently lost.
    always_comb begin
        timeoutFlag_d = timeoutFlag_q;
        protoFlag_d   = protoFlag_q;
        if (clearAllowed) begin
            timeoutFlag_d = 1'b0;
            protoFlag_d   = 1'b0;
        end
        if (stallTimeout) timeoutFlag_d = 1'b1;
        if (protoEvent)   protoFlag_d   = 1'b1;
    end

    // State, flags and the irq edge detector, which fires the cycle after a
    // flag goes from clear to set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= MONITOR;
            timeoutFlag_q <= 1'b0;
            protoFlag_q   <= 1'b0;
            timeoutDly_q  <= 1'b0;
            protoDly_q    <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            timeoutFlag_q <= timeoutFlag_d;
            protoFlag_q   <= protoFlag_d;
            timeoutDly_q  <= timeoutFlag_q;
            protoDly_q    <= protoFlag_q;
            irq_q         <= (timeoutFlag_q & ~timeoutDly_q) | (protoFlag_q & ~protoDly_q);
        end
    end

    assign timeout_o   = timeoutFlag_q;
    assign proto_err_o = protoFlag_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_axi_out_watchdog.sv
// Self-checking bench for axi_out_watchdog: a table of single-cycle bus
// vectors for the counters, then hand-written multi-cycle sequences for
// stall timeout, isolation handshake, progress, disable and reset.
module tb_axi_out_watchdog;

    localparam int CntWidth = 16;
    localparam int OutWidth = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic [CntWidth-1:0] timeoutCfg;
    logic                clear;
    logic                awValid, awReady, wValid, wReady, bValid, bReady;
    logic                arValid, arReady, rValid, rReady, rLast;
    logic                isolated;
    logic                isolateReq, timeoutFlag, protoErr, irq;
    logic [OutWidth-1:0] wrOut, rdOut;

    int checks = 0;
    int errors = 0;
    logic sawIso;

    typedef struct {
        logic  aw;
        logic  b;
        logic  ar;
        logic  r;
        logic  rl;
        logic  clr;
        int    expWr;
        int    expRd;
        int    expProto;
        string name;
    } vec_t;

    vec_t vecs[17];

    axi_out_watchdog dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .timeout_i        (timeoutCfg),
        .clear_i          (clear),
        .aw_valid_i       (awValid),
        .aw_ready_i       (awReady),
        .w_valid_i        (wValid),
        .w_ready_i        (wReady),
        .b_valid_i        (bValid),
        .b_ready_i        (bReady),
        .ar_valid_i       (arValid),
        .ar_ready_i       (arReady),
        .r_valid_i        (rValid),
        .r_ready_i        (rReady),
        .r_last_i         (rLast),
        .isolated_i       (isolated),
        .isolate_req_o    (isolateReq),
        .timeout_o        (timeoutFlag),
        .proto_err_o      (protoErr),
        .irq_o            (irq),
        .wr_outstanding_o (wrOut),
        .rd_outstanding_o (rdOut)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic setBus(input logic aw, input logic b, input logic ar,
                          input logic r, input logic rl);
        awValid = aw; awReady = aw;
        bValid  = b;  bReady  = b;
        arValid = ar; arReady = ar;
        rValid  = r;  rReady  = r;
        rLast   = rl;
    endtask

    task automatic applyStimulus(input vec_t v);
        setBus(v.aw, v.b, v.ar, v.r, v.rl);
        clear = v.clr;
        tick();
        checkOutput({v.name, " wr"},    int'(wrOut),      v.expWr);
        checkOutput({v.name, " rd"},    int'(rdOut),      v.expRd);
        checkOutput({v.name, " proto"}, int'(protoErr),   v.expProto);
        checkOutput({v.name, " iso"},   int'(isolateReq), 0);
    endtask

    task automatic doReset();
        setBus(0, 0, 0, 0, 0);
        wValid = 0; wReady = 0;
        clear = 0; isolated = 0; enable = 1;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        // aw b ar r rl clr | wr rd proto
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, "aw1"};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 2, 0, 0, "aw2"};
        vecs[2]  = '{1, 0, 0, 0, 0, 0, 3, 0, 0, "aw3"};
        vecs[3]  = '{0, 1, 0, 0, 0, 0, 2, 0, 0, "b1"};
        vecs[4]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0, "b2"};
        vecs[5]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, "b3"};
        vecs[6]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, "aw4"};
        vecs[7]  = '{1, 0, 0, 0, 0, 0, 2, 0, 0, "aw5"};
        vecs[8]  = '{1, 1, 0, 0, 0, 0, 2, 0, 0, "aw_b_same"};
        vecs[9]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0, "b4"};
        vecs[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, "b5"};
        vecs[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, "b_underflow"};
        vecs[12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, "clear_monitor"};
        vecs[13] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, "ar1"};
        vecs[14] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, "r_notlast"};
        vecs[15] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, "r_last"};
        vecs[16] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, "ar_rlast_same"};

        timeoutCfg = 16'd20;
        doReset();
        checkOutput("reset iso",   int'(isolateReq),  0);
        checkOutput("reset to",    int'(timeoutFlag), 0);
        checkOutput("reset proto", int'(protoErr),    0);
        checkOutput("reset irq",   int'(irq),         0);
        checkOutput("reset wr",    int'(wrOut),       0);
        checkOutput("reset rd",    int'(rdOut),       0);

        $display("[TB] table vectors");
        for (int i = 0; i < 17; i++) applyStimulus(vecs[i]);
        setBus(0, 0, 0, 0, 0);
        clear = 0;

        $display("[TB] overflow");
        doReset();
        for (int i = 0; i < 8; i++) begin
            setBus(1, 0, 0, 0, 0);
            tick();
        end
        checkOutput("ovf wr8",    int'(wrOut),    8);
        checkOutput("ovf proto0", int'(protoErr), 0);
        tick();
        setBus(0, 0, 0, 0, 0);
        checkOutput("ovf wr sat", int'(wrOut),      8);
        checkOutput("ovf proto1", int'(protoErr),   1);
        checkOutput("ovf irq0",   int'(irq),        0);
        checkOutput("ovf iso",    int'(isolateReq), 0);
        tick();
        checkOutput("ovf irq1",   int'(irq), 1);
        tick();
        checkOutput("ovf irq2",   int'(irq), 0);

        $display("[TB] write stall");
        timeoutCfg = 16'd10;
        doReset();
        setBus(1, 0, 0, 0, 0);
        tick();
        setBus(0, 0, 0, 0, 0);
        checkOutput("stall wr1", int'(wrOut), 1);
        for (int k = 1; k <= 13; k++) begin
            tick();
            checkOutput($sformatf("stall iso c%0d", k), int'(isolateReq), (k >= 11) ? 1 : 0);
            checkOutput($sformatf("stall to c%0d", k),  int'(timeoutFlag), (k >= 11) ? 1 : 0);
            checkOutput($sformatf("stall irq c%0d", k), int'(irq), (k == 12) ? 1 : 0);
        end
        clear = 1;
        tick();
        clear = 0;
        checkOutput("isolating clr iso", int'(isolateReq),  1);
        checkOutput("isolating clr to",  int'(timeoutFlag), 1);
        checkOutput("isolating clr wr",  int'(wrOut),       1);
        isolated = 1;
        tick();
        checkOutput("isolated iso", int'(isolateReq), 1);
        clear = 1;
        tick();
        clear = 0;
        checkOutput("release iso", int'(isolateReq),  0);
        checkOutput("release wr",  int'(wrOut),       0);
        checkOutput("release to",  int'(timeoutFlag), 0);
        isolated = 0;
        tick();
        sawIso = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (isolateReq) sawIso = 1;
        end
        checkOutput("monitor again iso", int'(sawIso),      0);
        checkOutput("monitor again to",  int'(timeoutFlag), 0);

        $display("[TB] read progress");
        timeoutCfg = 16'd5;
        doReset();
        setBus(0, 0, 1, 0, 0);
        tick();
        sawIso = 0;
        for (int i = 1; i <= 40; i++) begin
            setBus(0, 0, 0, (i % 4) == 0, 0);
            tick();
            if (isolateReq) sawIso = 1;
        end
        setBus(0, 0, 0, 0, 0);
        checkOutput("progress iso", int'(sawIso),      0);
        checkOutput("progress to",  int'(timeoutFlag), 0);
        checkOutput("progress rd",  int'(rdOut),       1);

        $display("[TB] disable");
        timeoutCfg = 16'd0;
        doReset();
        setBus(0, 0, 1, 0, 0);
        tick();
        setBus(0, 0, 0, 0, 0);
        sawIso = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (isolateReq) sawIso = 1;
        end
        checkOutput("thresh0 iso", int'(sawIso),      0);
        checkOutput("thresh0 to",  int'(timeoutFlag), 0);
        enable = 0;
        timeoutCfg = 16'd10;
        sawIso = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (isolateReq) sawIso = 1;
        end
        checkOutput("disabled iso", int'(sawIso),      0);
        checkOutput("disabled to",  int'(timeoutFlag), 0);
        enable = 1;
        for (int i = 0; i < 10; i++) tick();
        checkOutput("reenable iso early", int'(isolateReq), 0);
        tick();
        checkOutput("reenable iso", int'(isolateReq),  1);
        checkOutput("reenable to",  int'(timeoutFlag), 1);

        $display("[TB] reset while isolating");
        rst = 1;
        tick();
        checkOutput("rst iso",   int'(isolateReq),  0);
        checkOutput("rst to",    int'(timeoutFlag), 0);
        checkOutput("rst proto", int'(protoErr),    0);
        checkOutput("rst irq",   int'(irq),         0);
        checkOutput("rst wr",    int'(wrOut),       0);
        checkOutput("rst rd",    int'(rdOut),       0);
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
